// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore serial pattern detector with saturating match count; SEQDET_LOAD_EN adds runtime pattern load
module moore_seq_detector #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               j,
`ifdef SEQDET_LOAD_EN
    input  logic               load,
    input  logic [PAT_LEN-1:0] pat_in,
`endif
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
    logic [PAT_LEN-1:0] hist, hist_n, pat;
    logic [FW-1:0]      fill, fill_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               trunc, match_n;
    assign w       = (fill == FULL) && (hist == pat);
    assign cnt_sat = &match_cnt;
    assign trunc   = !OVERLAP && w;
    always_comb begin
        hist_n  = !en ? hist : trunc ? {{(PAT_LEN-1){1'b0}}, j} : {hist[PAT_LEN-2:0], j};
        fill_n  = !en ? fill : trunc ? FW'(1) : (fill == FULL) ? fill : fill + 1'b1;
        match_n = en && (fill_n == FULL) && (hist_n == pat);
        cnt_n   = (match_n && !cnt_sat) ? match_cnt + 1'b1 : match_cnt;
    end
`ifndef SEQDET_LOAD_EN
    assign pat = PATTERN;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
`ifdef SEQDET_LOAD_EN
            pat       <= PATTERN;
        end else if (load) begin
            pat       <= pat_in;
            hist      <= '0;
            fill      <= '0;
`endif
        end else begin
            hist      <= hist_n;
            fill      <= fill_n;
            match_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: directed checks of detection, overlap modes, en gating, reset, saturation and pattern load
module tb_moore_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic j   = 1'b0;
    logic load = 1'b0;
    logic [4:0] pat_in = 5'b0;
    logic w, sat, w_no, sat_no, w_c2, sat_c2;
    logic [7:0] cnt, cnt_no;
    logic [1:0] cnt_c2;
    int asserts = 0;
    int fails = 0;
    always #5 clk = ~clk;
    moore_seq_detector dut (
        .clk(clk), .rst(rst), .en(en), .j(j),
`ifdef SEQDET_LOAD_EN
        .load(load), .pat_in(pat_in),
`endif
        .w(w), .match_cnt(cnt), .cnt_sat(sat));
    moore_seq_detector #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .en(en), .j(j),
`ifdef SEQDET_LOAD_EN
        .load(load), .pat_in(pat_in),
`endif
        .w(w_no), .match_cnt(cnt_no), .cnt_sat(sat_no));
    moore_seq_detector #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .j(j),
`ifdef SEQDET_LOAD_EN
        .load(load), .pat_in(pat_in),
`endif
        .w(w_c2), .match_cnt(cnt_c2), .cnt_sat(sat_c2));
    task automatic step(input logic e, input logic b);
        @(negedge clk);
        en = e;
        j  = b;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask
    task automatic test_reset;
        do_reset();
        asserts++; if (w !== 1'b0) begin fails++; $display("FAIL reset_w got %b exp 0", w); end
        asserts++; if (cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        asserts++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b exp 0", sat); end
        asserts++; if (cnt_c2 !== 2'd0) begin fails++; $display("FAIL reset_cnt_c2 got %0d exp 0", cnt_c2); end
    endtask
    task automatic test_basic;
        logic [4:0] s = 5'b10010;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, s[i]);
            asserts++; if (w !== (i == 0)) begin fails++; $display("FAIL basic_w edge %0d got %b exp %b", 5 - i, w, i == 0); end
        end
        asserts++; if (cnt !== 8'd1) begin fails++; $display("FAIL basic_cnt got %0d exp 1", cnt); end
        step(1'b1, 1'b1);
        asserts++; if (w !== 1'b0) begin fails++; $display("FAIL basic_w_drop got %b exp 0", w); end
    endtask
    task automatic test_overlap;
        logic [7:0] s    = 8'b10010010;
        logic [7:0] e_ov = 8'b00001001;
        logic [7:0] e_no = 8'b00001000;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, s[i]);
            asserts++; if (w !== e_ov[i]) begin fails++; $display("FAIL overlap_w edge %0d got %b exp %b", 8 - i, w, e_ov[i]); end
            asserts++; if (w_no !== e_no[i]) begin fails++; $display("FAIL nonoverlap_w edge %0d got %b exp %b", 8 - i, w_no, e_no[i]); end
        end
        asserts++; if (cnt !== 8'd2) begin fails++; $display("FAIL overlap_cnt got %0d exp 2", cnt); end
        asserts++; if (cnt_no !== 8'd1) begin fails++; $display("FAIL nonoverlap_cnt got %0d exp 1", cnt_no); end
    endtask
    task automatic test_reset_mid;
        logic [6:0] s = 7'b1010010;
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s[i]);
            asserts++; if (w !== (i == 0)) begin fails++; $display("FAIL resetmid_w edge %0d got %b exp %b", 7 - i, w, i == 0); end
            if (i == 5) begin
                asserts++; if (cnt !== 8'd0) begin fails++; $display("FAIL resetmid_cnt0 got %0d exp 0", cnt); end
            end
        end
        asserts++; if (cnt !== 8'd1) begin fails++; $display("FAIL resetmid_cnt got %0d exp 1", cnt); end
    endtask
    task automatic test_en_gating;
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            asserts++; if (w !== 1'b0) begin fails++; $display("FAIL engate_hold_w cycle %0d got %b exp 0", i, w); end
        end
        step(1'b1, 1'b0);
        asserts++; if (w !== 1'b1) begin fails++; $display("FAIL engate_match_w got %b exp 1", w); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, ~i[0]);
            asserts++; if (w !== 1'b1) begin fails++; $display("FAIL engate_keep_w cycle %0d got %b exp 1", i, w); end
        end
        asserts++; if (cnt !== 8'd1) begin fails++; $display("FAIL engate_cnt got %0d exp 1", cnt); end
    endtask
    task automatic test_saturation;
        logic [16:0] s  = 17'b10010010010010010;
        logic [16:0] em = 17'b00001001001001001;
        int e_cnt = 0;
        do_reset();
        for (int i = 16; i >= 0; i--) begin
            step(1'b1, s[i]);
            if (em[i]) begin
                e_cnt = (e_cnt == 3) ? 3 : e_cnt + 1;
                asserts++; if (cnt_c2 !== 2'(e_cnt)) begin fails++; $display("FAIL sat_cnt edge %0d got %0d exp %0d", 17 - i, cnt_c2, e_cnt); end
                asserts++; if (sat_c2 !== (e_cnt == 3)) begin fails++; $display("FAIL sat_flag edge %0d got %b exp %b", 17 - i, sat_c2, e_cnt == 3); end
            end
        end
        asserts++; if (cnt !== 8'd5) begin fails++; $display("FAIL sat_wide_cnt got %0d exp 5", cnt); end
        asserts++; if (sat !== 1'b0) begin fails++; $display("FAIL sat_wide_flag got %b exp 0", sat); end
    endtask
`ifdef SEQDET_LOAD_EN
    task automatic test_load;
        logic [4:0] s_old = 5'b10010;
        logic [4:0] s_new = 5'b11011;
        do_reset();
        for (int i = 4; i >= 0; i--) step(1'b1, s_old[i]);
        asserts++; if (w !== 1'b1) begin fails++; $display("FAIL load_pre_w got %b exp 1", w); end
        @(negedge clk);
        load = 1'b1; pat_in = 5'b11011; en = 1'b1; j = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        asserts++; if (w !== 1'b0) begin fails++; $display("FAIL load_w got %b exp 0", w); end
        asserts++; if (cnt !== 8'd1) begin fails++; $display("FAIL load_cnt_kept got %0d exp 1", cnt); end
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, s_new[i]);
            asserts++; if (w !== (i == 0)) begin fails++; $display("FAIL load_new_w edge %0d got %b exp %b", 5 - i, w, i == 0); end
        end
        asserts++; if (cnt !== 8'd2) begin fails++; $display("FAIL load_new_cnt got %0d exp 2", cnt); end
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, s_old[i]);
            asserts++; if (w !== 1'b0) begin fails++; $display("FAIL load_old_w edge %0d got %b exp 0", 5 - i, w); end
        end
        asserts++; if (cnt !== 8'd2) begin fails++; $display("FAIL load_old_cnt got %0d exp 2", cnt); end
    endtask
`endif
    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_reset_mid();
        test_en_gating();
        test_saturation();
`ifdef SEQDET_LOAD_EN
        test_load();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
Parametrised Moore-type serial sequence detector, the generalised successor to the fixed 10010 detector. Detects a PAT_LEN-bit pattern on serial input j and selects overlapping or non-overlapping matching. Keeps a saturating match counter. Sits on a serial bit stream next to other lab FSM blocks and is driven by a qualifying sample enable.

Parameters:
PAT_LEN, 5, pattern length in bits (2..16).
PATTERN, 5'b10010, reset/default pattern, MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
CNT_W, 8, match counter width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst=0 resets on clk rising edge)
en  in  1  sample qualifier; j is consumed only on edges with en=1
j  in  1  serial data bit
load  in  1  pattern load strobe (present only with SEQDET_LOAD_EN)
pat_in  in  PAT_LEN  new pattern, MSB first bit (present only with SEQDET_LOAD_EN)
w  out  1  Moore detect output
match_cnt  out  CNT_W  number of matches seen, saturating
cnt_sat  out  1  high when match_cnt is all ones

Behaviour:
- State: hist[PAT_LEN-1:0] holds the last bits received, newest in LSB. fill counts 0..PAT_LEN valid bits and saturates at PAT_LEN. pat[PAT_LEN-1:0] is the active pattern.
- Reset (rst=0 at an edge): hist=0, fill=0, pat=PATTERN, match_cnt=0. This gives w=0 and cnt_sat=0. Reset mid-sequence discards partial history, so a later match needs a full PAT_LEN fresh bits.
- Shift (en=1, no load): hist <= {hist[PAT_LEN-2:0], j}; fill <= min(fill+1, PAT_LEN).
- w = (fill==PAT_LEN) && (hist==pat). w is a pure function of state (Moore), with no combinational path from j or en.
- Latency: w rises in the cycle after the edge that shifts in the last pattern bit.
- w holds while en=0, because state is frozen. It drops on the next shift unless that shift also completes a match.
- OVERLAP=0: on a shift edge taken while w=1, fill <= 1 and hist <= {0..0, j}. The bit sampled on that edge becomes the first bit of a new candidate.
- OVERLAP=1: history is never truncated, so suffix/prefix overlaps match.
- Counter: on any shift edge whose next state satisfies the match condition, match_cnt <= match_cnt+1.
  - match_cnt saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat = &match_cnt.
- en=0: no state change. j is ignored.
- Priority at each edge: reset > load > shift > hold.

Optional Feature:
Macro SEQDET_LOAD_EN.
- Defined: ports load and pat_in exist. An edge with load=1 (rst=1) does pat <= pat_in, hist <= 0, fill <= 0; match_cnt is preserved.
  - Any en/j on that edge is ignored.
  - w is 0 in the following cycle.
- Undefined: ports are absent and pat is constant PATTERN; the register and mux are not built.

Test Plan:
1. Reset, en=1, j = 1,0,0,1,0 (PATTERN 10010) -> w=0 through edge 4; w=1 for the one cycle after edge 5; match_cnt=1.
2. OVERLAP=1, j = 1,0,0,1,0,0,1,0 -> w pulses after edge 5 and after edge 8; match_cnt=2.
   Same stream with OVERLAP=0 -> only the edge-5 match; match_cnt=1.
3. j = 1,0,0 then rst=0 for one edge, then j = 1,0 -> no match, w=0, match_cnt=0. Then j = 1,0,0,1,0 -> match, match_cnt=1.
4. en gating: j=1,0,0,1 with en=1, then en=0 for 3 cycles with j toggling, then en=1 with j=0 -> w=1 only after the final en edge. w stays 1 while en is subsequently held 0.
5. CNT_W=2, OVERLAP=1, repeated 10010 stream with 5 matches -> match_cnt goes 1,2,3,3,3; cnt_sat=1 from the third match on.
6. With SEQDET_LOAD_EN: load=1 with pat_in=11011 mid-stream -> w=0 and history cleared. Then j=1,1,0,1,1 -> w=1 and match_cnt increments. The old pattern 10010 no longer matches.
